addtree_chan_sched: RTL and testbench
=====================================

# addtree_chan_sched

Scheduler and channel accumulator for the shared 26-input adder tree (`AddTree_26p`, 5x5 kernel products plus bias). It accepts one 26-operand beat per input channel over a valid/ready interface and drives the tree with it. It tracks the tree's fixed pipeline latency, accumulates `C_IN` tree results into one output-pixel sum, and buffers finished sums in a small FIFO behind credit-based flow control. It sits between the multiplier array and the activation/pooling stage of the convolution layer.

## Interface
- `DATA_W`, 16: operand, tree and sum width (two's complement).
- `N_IN`, 26: operands per beat; fixed to the tree's input count.
- `C_IN`, 6: beats (input channels) per output sum; range 1..255.
- `TREE_LAT`, 3: adder-tree latency in cycles from `tree_in` to `tree_out`; must be at least 1.
- `FIFO_DEPTH`, 4: completed-sum FIFO entries; power of two.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: an operand beat is present.
- `in_ready` out 1: the beat is accepted this cycle.
- `in_data` in `N_IN*DATA_W`: operand k is at bits `[k*DATA_W +: DATA_W]`.
- `tree_in` out `N_IN*DATA_W`: to the tree inputs `in_00`..`in_25`.
- `tree_out` in `DATA_W`: tree `out`.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: the consumer takes the head.
- `out_data` out `DATA_W`: accumulated sum.
- `busy` out 1: a group is open, in flight, or buffered.

## Operation
- `tree_in` is `in_data` passed through combinationally. An accepted beat (`in_valid & in_ready`) enters the valid shift register `vpipe[TREE_LAT-1:0]`. The tree output is consumed when `vpipe` exits.
- Issue FSM:
  - IDLE: no group open. Accepting a beat needs `credits > 0`. On acceptance, reserve one credit and set `beat_cnt = 1`. If `C_IN == 1` stay in IDLE, else go to RUN.
  - RUN: `in_ready = 1` unconditionally, because the credit is already held. Each accepted beat increments `beat_cnt`. When beat `C_IN` is accepted, clear `beat_cnt` and go to IDLE.
- Credits:
  - `credits = FIFO_DEPTH - fifo_count - reserved`.
  - Reserve happens on the first beat of a group. Release happens on a FIFO pop. If both occur in the same cycle they net to zero.
  - The FIFO can never overflow, so `in_ready` has no dependence on `out_ready` within an open group.
- Accumulator side: `res_cnt` counts exiting tree results.
  - Result 0 loads `acc = tree_out`.
  - Results 1..`C_IN-2` apply `acc = acc + tree_out`.
  - Result `C_IN-1` writes `acc + tree_out` into the FIFO. `reserved` decrements and `fifo_count` increments in the same cycle.
- Sum arithmetic is `DATA_W`-bit; overflow behaviour is set under Configuration. The tree's own internal wrap is not checked.
- Gaps between beats (`in_valid` low) are allowed anywhere. Groups are back-to-back with no bubble.

## Timing
- Reset values: `in_ready = 0` during reset, then 1 from the first cycle after release (credits = `FIFO_DEPTH`). `out_valid = 0`, `out_data = 0`, `busy = 0`, `vpipe = 0`, counters 0, FSM in IDLE.
- A beat accepted at cycle t has its tree result used at cycle t+`TREE_LAT`.
- The last beat of a group accepted at t gives `out_valid = 1` at t+`TREE_LAT`+1 with an empty FIFO (minimum latency `TREE_LAT`+1).
- Throughput is one beat per cycle sustained while credits are available.
- `out_valid`/`out_data` are FIFO-head registers: stable while `out_valid & ~out_ready`. A pop and a push in the same cycle on a full FIFO are legal.
- Reset mid-group or mid-flight discards open groups, in-flight results and buffered sums. Stale tree contents after reset are ignored because `vpipe` is cleared.

## Configuration
- `ADDTREE_ACC_SAT_EN` defined: each accumulate is computed at `DATA_W+1` bits and clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- `ADDTREE_ACC_SAT_EN` undefined: plain `DATA_W`-bit two's-complement wrap. This matches the tree's behaviour.

## Structure
- Shared package `cnn_pkg`: `DATA_W`, `N_IN`, the FSM state enum (`ST_IDLE`, `ST_RUN`), and a saturating-add function used only under the macro.
- One sub-module, `sum_fifo`: synchronous FIFO of `FIFO_DEPTH` x `DATA_W` with count output and registered head.
- The tree itself is instantiated by the parent, not inside this block.

## Test plan
Bench wraps the real tree with `TREE_LAT=3`, `C_IN=6`, `FIFO_DEPTH=4`.
- All operands 1, 6 back-to-back beats -> one `out_data = 156`, `out_valid` 4 cycles after the last beat.
- Beat c has operands k+c for k=0..25, c=0..5 -> `out_data = 325*6 + 26*15 = 2340`. With operands negated -> `-2340`.
- All operands 1000 for 6 beats -> `156000` overflows: 32767 with `ADDTREE_ACC_SAT_EN`, 24928 without.
- `out_ready = 0`, 5 groups offered -> 4 sums buffered and `in_ready = 0` on the 5th group's first beat. Raising `out_ready` for one cycle -> `in_ready = 1` the next cycle, and sums pop in order.
- Random `in_valid` gaps inside groups -> sums equal the golden model and group boundaries hold.
- Assert `rst_n = 0` after 3 beats of a group -> all outputs reach reset values. A fresh full group then yields the correct sum with no leftover partial.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants, scheduler state type and the saturating add used when
// ADDTREE_ACC_SAT_EN is defined.
package cnn_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_IN   = 26;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  // Add at DATA_W+1 bits, clamp to the signed DATA_W range on overflow.
  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_add = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sat_add = sum[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sum_fifo.sv
// Completed-sum FIFO: DEPTH x WIDTH ring with occupancy count and a registered head
// (out_valid/out_data are flops loaded from the next-state ring contents).
module sum_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok;

  assign pop_ok = pop & (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    head_valid_d = (cnt_d != '0);
    head_d       = head_valid_d ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign out_valid = head_valid_q;
  assign out_data  = head_q;
  assign count     = cnt_q;

endmodule

// File: rtl/addtree_chan_sched.sv
// Adder-tree issue scheduler and per-pixel channel accumulator with credit-gated sum FIFO.
// Optional feature macro: ADDTREE_ACC_SAT_EN (saturating accumulate instead of wrap).
module addtree_chan_sched
  import cnn_pkg::*;
#(
  parameter int unsigned C_IN       = 6,
  parameter int unsigned TREE_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*DATA_W-1:0] in_data,
  output logic [N_IN*DATA_W-1:0] tree_in,
  input  logic [DATA_W-1:0]      tree_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   busy
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]  LastIdx = 8'(C_IN - 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

  sched_state_e          state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [7:0]            res_cnt_q, res_cnt_d;
  logic [DATA_W-1:0]     acc_q, acc_d;
  logic [TREE_LAT-1:0]   vpipe_q, vpipe_d;
  logic [CntW-1:0]       reserved_q, reserved_d;
  logic                  ready_en_q;
  logic [CntW-1:0]       fifo_count;
  logic                  accept, reserve, has_credit, exit_valid;
  logic                  push, pop;
  logic [DATA_W-1:0]     push_data, sum_next;

  assign tree_in    = in_data;
  assign accept     = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign exit_valid = vpipe_q[TREE_LAT-1];
  assign has_credit = ({1'b0, fifo_count} + {1'b0, reserved_q}) < DepthC;

  // An open group already holds its FIFO slot, so RUN never waits on the consumer.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready = ready_en_q & has_credit;
      ST_RUN:  in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    reserve    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          reserve = 1'b1;
          if (C_IN == 1) begin
            beat_cnt_d = 8'd0;
          end else begin
            beat_cnt_d = 8'd1;
            state_d    = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (beat_cnt_q == LastIdx) begin
            beat_cnt_d = 8'd0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ADDTREE_ACC_SAT_EN
  assign sum_next = sat_add(acc_q, tree_out);
`else
  assign sum_next = acc_q + tree_out;
`endif

  always_comb begin
    vpipe_d[0] = accept;
    for (int i = 1; i < int'(TREE_LAT); i++) vpipe_d[i] = vpipe_q[i-1];
    res_cnt_d = res_cnt_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_data = sum_next;
    if (exit_valid) begin
      if (res_cnt_q == LastIdx) begin
        push      = 1'b1;
        push_data = (res_cnt_q == 8'd0) ? tree_out : sum_next;
        res_cnt_d = 8'd0;
      end else if (res_cnt_q == 8'd0) begin
        acc_d     = tree_out;
        res_cnt_d = 8'd1;
      end else begin
        acc_d     = sum_next;
        res_cnt_d = res_cnt_q + 8'd1;
      end
    end
  end

  // A reservation moves into fifo_count when its sum is pushed.
  always_comb begin
    unique case ({reserve, push})
      2'b10:   reserved_d = reserved_q + CntW'(1);
      2'b01:   reserved_d = reserved_q - CntW'(1);
      default: reserved_d = reserved_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 8'd0;
      res_cnt_q  <= 8'd0;
      acc_q      <= '0;
      vpipe_q    <= '0;
      reserved_q <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      res_cnt_q  <= res_cnt_d;
      acc_q      <= acc_d;
      vpipe_q    <= vpipe_d;
      reserved_q <= reserved_d;
      ready_en_q <= 1'b1;
    end
  end

  sum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CntW)
  ) u_sum_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (fifo_count)
  );

  assign busy = (state_q == ST_RUN) | (|vpipe_q) | (reserved_q != '0) | (fifo_count != '0);

endmodule

// File: tb/tb_addtree_chan_sched.sv
// Directed bench for addtree_chan_sched with a 3-cycle wrapping adder-tree model.
module tb_addtree_chan_sched;

  localparam int DW = 16;
  localparam int NI = 26;
  localparam int BW = DW * NI;

  logic          clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [BW-1:0] in_data, tree_in;
  logic [DW-1:0] tree_out, out_data;
  logic [DW-1:0] tree_pipe [3];
  logic [DW-1:0] got [$];
  int            checks, errors;

  addtree_chan_sched #(
    .C_IN       (6),
    .TREE_LAT   (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tree_in   (tree_in),
    .tree_out  (tree_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat_sum(input logic [BW-1:0] b);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < NI; k++) s = s + b[k*DW +: DW];
    return s;
  endfunction

  function automatic logic [BW-1:0] beat_const(input int v);
    logic [BW-1:0] b;
    for (int k = 0; k < NI; k++) b[k*DW +: DW] = 16'(v);
    return b;
  endfunction

  function automatic logic [BW-1:0] beat_ramp(input int c, input bit neg);
    logic [BW-1:0] b;
    for (int k = 0; k < NI; k++) b[k*DW +: DW] = neg ? 16'(-(k + c)) : 16'(k + c);
    return b;
  endfunction

  // Tree model: wrapping 26-input sum with three register stages.
  always @(posedge clk) begin
    tree_pipe[0] <= beat_sum(tree_in);
    tree_pipe[1] <= tree_pipe[0];
    tree_pipe[2] <= tree_pipe[1];
  end
  assign tree_out = tree_pipe[2];

  // Inputs change just after posedge, so negedge sees the handshake of the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic send_beat(input logic [BW-1:0] d, output bit ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_const_group(input int v, output bit ok);
    bit b;
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      send_beat(beat_const(v), b);
      ok &= b;
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    int cyc;
    cyc = 0;
    while (got.size() < n && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = (got.size() >= n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_ones_latency;
    bit ok;
    got.delete();
    out_ready = 1'b1;
    send_const_group(1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ones_accept: beats not accepted back-to-back"); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy: got %b want 1", busy); end
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL ones_early_valid: cycle +%0d got %b want 0", i, out_valid);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency: got %b want 1", out_valid); end
    checks++;
    if (out_data !== 16'd156) begin errors++; $display("FAIL ones_sum: got %0d want 156", out_data); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ones_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_ramp;
    bit ok, b;
    got.delete();
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 6; c++) send_beat(beat_ramp(c, n == 1), b);
    end
    wait_results(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ramp_timeout: got %0d sums want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'd2340) begin errors++; $display("FAIL ramp_pos: got %0d want 2340", got[0]); end
      checks++;
      if (got[1] !== 16'hF6DC) begin
        errors++; $display("FAIL ramp_neg: got %0d want %0d", $signed(got[1]), -2340);
      end
    end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [DW-1:0] exp;
`ifdef ADDTREE_ACC_SAT_EN
    exp = 16'd32767;
`else
    exp = 16'd24928;
`endif
    got.delete();
    out_ready = 1'b1;
    send_const_group(1000, ok);
    wait_results(1, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL overflow_timeout: no sum");
    end else if (got[0] !== exp) begin
      errors++; $display("FAIL overflow_sum: got %0d want %0d", got[0], exp);
    end
  endtask

  task automatic test_credits;
    bit ok, b;
    got.delete();
    out_ready = 1'b0;
    ok = 1'b1;
    for (int g = 0; g < 4; g++) begin
      send_const_group(g + 1, b);
      ok &= b;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL credits_fill: 4 groups not accepted"); end
    in_valid = 1'b1;
    in_data  = beat_const(5);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL credits_block: got %b want 0", in_ready); end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd156) begin
      errors++; $display("FAIL credits_head: valid %b data %0d want 1/156", out_valid, out_data);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL credits_full: in_ready %b busy %b want 0/1", in_ready, busy);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL credits_release: got %b want 1", in_ready); end
    checks++;
    if (out_data !== 16'd312) begin errors++; $display("FAIL credits_next_head: got %0d want 312", out_data); end
    send_const_group(5, b);
    checks++;
    if (!b) begin errors++; $display("FAIL credits_fifth: group not accepted"); end
    out_ready = 1'b1;
    wait_results(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL credits_timeout: got %0d sums want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== 16'(156 * (i + 1))) begin
          errors++; $display("FAIL credits_order[%0d]: got %0d want %0d", i, got[i], 156 * (i + 1));
        end
      end
    end
  endtask

  task automatic test_gaps;
    bit ok, b;
    logic [BW-1:0] beat;
    logic [DW-1:0] exp [2];
    got.delete();
    out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      exp[g] = '0;
      for (int c = 0; c < 6; c++) begin
        for (int k = 0; k < NI; k++) beat[k*DW +: DW] = 16'($urandom_range(0, 100));
        exp[g] = exp[g] + beat_sum(beat);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_beat(beat, b);
      end
    end
    wait_results(2, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL gaps_timeout: got %0d sums want 2", got.size());
    end else begin
      for (int g = 0; g < 2; g++) begin
        checks++;
        if (got[g] !== exp[g]) begin
          errors++; $display("FAIL gaps_sum[%0d]: got %0d want %0d", g, got[g], exp[g]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_group;
    bit ok, b;
    got.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) send_beat(beat_const(7), b);
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL midreset_outputs: in_ready %b out_valid %b busy %b data %0d want 0/0/0/0",
               in_ready, out_valid, busy, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_const_group(1, b);
    wait_results(1, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got.size() !== 1) begin
      errors++; $display("FAIL midreset_count: got %0d sums want 1", got.size());
    end else begin
      checks++;
      if (got[0] !== 16'd156) begin errors++; $display("FAIL midreset_sum: got %0d want 156", got[0]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ones_latency();
    test_ramp();
    test_overflow();
    test_credits();
    test_gaps();
    test_reset_mid_group();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
